// File: rtl/lif_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lif_acc_pkg
// Description : Shared constants for the neuron-core spike output path.
// Revision    : 1.0 - initial release
// ============================================================================
package lif_acc_pkg;

    localparam int c_def_n = 32;
    localparam int c_def_b = 8;
    localparam int c_def_w = 4;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_scan = 2'd1;
    localparam logic [1:0] c_st_eot  = 2'd2;

    localparam logic [c_def_b-1:0] c_eot_marker = 8'hFF;

endpackage : lif_acc_pkg
`default_nettype wire

// File: rtl/spike_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spike_fifo
// Description : Show-ahead circular FIFO with synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_fifo #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [B-1:0] i_push_data,
    input  logic         i_pop,
    output logic [B-1:0] o_pop_data,
    output logic         o_full,
    output logic [W:0]   o_count
);

    localparam logic [W:0] c_depth = (W+1)'(1 << W);

    logic [B-1:0] r_mem [0:(1<<W)-1];
    logic [W-1:0] r_wr_ptr;
    logic [W-1:0] r_rd_ptr;
    logic [W:0]   r_count;
    logic         w_empty;
    logic         w_do_push;
    logic         w_do_pop;

    assign w_empty   = (r_count == '0);
    assign o_full    = (r_count == c_depth);
    assign o_count   = r_count;
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !w_empty && !i_flush;

    // Forced to zero when empty so the head word is defined after reset/flush.
    assign o_pop_data = w_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule : spike_fifo
`default_nettype wire

// File: rtl/spike_out_tx.sv
`default_nettype none
// ============================================================================
// Module      : spike_out_tx
// Description : Serialises fired-neuron vectors into spike IDs (+ optional
//               end-of-timestep marker) and streams them over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_out_tx
    import lif_acc_pkg::*;
#(
    parameter int N      = c_def_n,
    parameter int B      = c_def_b,
    parameter int W      = c_def_w,
    parameter int EOT_EN = 1,
    parameter int CW     = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          fire_valid_i,
    input  logic [N-1:0]  fire_vec_i,
    output logic          fire_ready_o,
    output logic          out_valid_o,
    output logic [B-1:0]  out_data_o,
    input  logic          out_ready_i,
    output logic          full_o,
    output logic          busy_o,
    output logic [CW-1:0] spike_cnt_o
);

    localparam logic [B-1:0] c_eot = '1;

    logic [1:0]    r_state;
    logic [N-1:0]  r_scan;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  w_scan_next;
    logic [1:0]    w_state_done;
    logic          w_push;
    logic [B-1:0]  w_push_data;
    logic          w_pop;
    logic          w_full;
    logic [W:0]    w_count;
    logic          w_empty;

    function automatic logic [B-1:0] lowest_idx(input logic [N-1:0] v);
        logic [B-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) idx = B'(i);
        end
        return idx;
    endfunction

    assign w_scan_next  = r_scan & (r_scan - N'(1));
    assign w_state_done = (EOT_EN != 0) ? c_st_eot : c_st_idle;
    assign w_empty      = (w_count == '0);

    // Push is gated on the registered full flag; a same-cycle pop never frees room.
    always_comb begin
        w_push      = 1'b0;
        w_push_data = lowest_idx(r_scan);
        if (!flush_i && !w_full) begin
            if (r_state == c_st_scan) begin
                w_push = 1'b1;
            end else if (r_state == c_st_eot) begin
                w_push      = 1'b1;
                w_push_data = c_eot;
            end
        end
    end

    assign w_pop = out_valid_o && out_ready_i && !flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
            r_scan  <= '0;
        end else if (flush_i) begin
            r_state <= c_st_idle;
            r_scan  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (fire_valid_i) begin
                        r_scan  <= fire_vec_i;
                        r_state <= (|fire_vec_i) ? c_st_scan : w_state_done;
                    end
                end
                c_st_scan: begin
                    if (!w_full) begin
                        r_scan <= w_scan_next;
                        if (w_scan_next == '0) r_state <= w_state_done;
                    end
                end
                c_st_eot: begin
                    if (!w_full) r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Markers are all-ones, a value no neuron index can take since N <= 2^B-1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (flush_i) begin
            r_cnt <= '0;
        end else if (w_pop && (out_data_o != c_eot) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    spike_fifo #(
        .B (B),
        .W (W)
    ) u_fifo (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_flush     (flush_i),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_pop_data  (out_data_o),
        .o_full      (w_full),
        .o_count     (w_count)
    );

    assign fire_ready_o = (r_state == c_st_idle);
    assign busy_o       = (r_state != c_st_idle);
    assign out_valid_o  = !w_empty;
    assign full_o       = w_full;
    assign spike_cnt_o  = r_cnt;

endmodule : spike_out_tx
`default_nettype wire
